// File: rtl/bram_copy_engine.sv
// Streams DEPTH words from a source BRAM read port to a destination BRAM write
// port, absorbing RD_LAT cycles of read latency; one-shot or free-running.
module bram_copy_engine #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 76800,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic              abort_i,
  output logic              src_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic [DATA_W-1:0] src_dout_i,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] dst_din_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       pass_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic              src_en_q, src_en_d;
  logic              dst_we_q, dst_we_d;
  logic [DATA_W-1:0] dst_din_q, dst_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;

  // Next-state and registered-output logic; abort overrides everything last.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    src_en_d   = 1'b0;
    dst_we_d   = 1'b0;
    dst_din_d  = dst_din_q;
    done_d     = 1'b0;
    pass_cnt_d = pass_cnt_q;
    vpipe_d    = RD_LAT'({vpipe_q, src_en_q});

    // Write side: dst address counts contiguous writes, first one lands at 0.
    if (vpipe_q[RD_LAT-1]) begin
      dst_we_d  = 1'b1;
      dst_din_d = src_dout_i;
      if (dst_we_q) begin
        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_READ;
          src_en_d = 1'b1;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      S_READ: begin
        if (rd_cnt_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          src_en_d = 1'b1;
          rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (dst_we_q && (wr_cnt_q == LAST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        pass_cnt_d = pass_cnt_q + 16'd1;
        if (continuous_i) begin
          state_d  = S_READ;
          src_en_d = 1'b1;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d    = S_IDLE;
      src_en_d   = 1'b0;
      dst_we_d   = 1'b0;
      done_d     = 1'b0;
      vpipe_d    = '0;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      pass_cnt_d = pass_cnt_q;
    end

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      vpipe_q    <= '0;
      src_en_q   <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      vpipe_q    <= vpipe_d;
      src_en_q   <= src_en_d;
      dst_we_q   <= dst_we_d;
      dst_din_q  <= dst_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign src_en_o   = src_en_q;
  assign src_addr_o = rd_cnt_q;
  assign dst_we_o   = dst_we_q;
  assign dst_addr_o = wr_cnt_q;
  assign dst_din_o  = dst_din_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_cnt_o = pass_cnt_q;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Bench for bram_copy_engine: three instances (RD_LAT 1, 2, 4) share stimulus;
// each is checked every cycle against a pass-timeline model of the copy.
module tb_bram_copy_engine;

  localparam int DEPTH = 8;

  logic clk;
  logic n_rst;
  logic start;
  logic abort;
  logic continuous;
  logic wrap_load;
  logic clr_dst;
  logic final_chk;

  logic [23:0] src_mem [DEPTH];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

    logic        src_en;
    logic [16:0] src_addr;
    logic [23:0] src_dout;
    logic        dst_we;
    logic [16:0] dst_addr;
    logic [23:0] dst_din;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;

    logic [23:0] rd_pipe [L];
    logic [23:0] dst_mem [DEPTH];

    // Reference: a pass is a timeline anchored at t0 (first read cycle).
    bit          act = 1'b0;
    int          t0 = 0;
    logic [15:0] passes = '0;

    bram_copy_engine #(
      .DATA_W(24), .ADDR_W(17), .DEPTH(DEPTH), .RD_LAT(L)
    ) u_dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start_i      (start),
      .continuous_i (continuous),
      .abort_i      (abort),
      .src_en_o     (src_en),
      .src_addr_o   (src_addr),
      .src_dout_i   (src_dout),
      .dst_we_o     (dst_we),
      .dst_addr_o   (dst_addr),
      .dst_din_o    (dst_din),
      .busy_o       (busy),
      .done_o       (done),
      .pass_cnt_o   (pass_cnt)
    );

    // Source BRAM with L cycles of read latency; junk when not enabled.
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (src_en && src_addr < 17'(DEPTH)) ? src_mem[src_addr[2:0]] : 24'($urandom);
    end
    assign src_dout = rd_pipe[L-1];

    always @(posedge clk) begin
      if (clr_dst) begin
        for (int i = 0; i < DEPTH; i++) dst_mem[i] <= 'x;
      end else if (dst_we && dst_addr < 17'(DEPTH)) begin
        dst_mem[dst_addr[2:0]] <= dst_din;
      end
    end

    always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        act    = 1'b0;
        passes = '0;
      end else begin
        if (abort) begin
          act = 1'b0;
        end else if (!act) begin
          if (start) begin
            act = 1'b1;
            t0  = cyc + 1;
          end
        end else if (cyc - t0 == DEPTH + L + 1) begin
          passes = passes + 16'd1;
          if (continuous) t0 = cyc + 1;
          else            act = 1'b0;
        end
        if (wrap_load) passes = 16'hFFFF;
      end
    end

    always @(negedge clk) begin : chk
      int   d;
      logic e_src, e_we, e_busy, e_done;
      d      = cyc - t0;
      e_src  = act && (d < DEPTH);
      e_busy = act && (d <= DEPTH + L);
      e_we   = act && (d >= L + 1) && (d <= DEPTH + L);
      e_done = act && (d == DEPTH + L + 1);
      check_eq($sformatf("L%0d src_en", L), 32'(src_en), 32'(e_src));
      check_eq($sformatf("L%0d dst_we", L), 32'(dst_we), 32'(e_we));
      check_eq($sformatf("L%0d busy", L), 32'(busy), 32'(e_busy));
      check_eq($sformatf("L%0d done", L), 32'(done), 32'(e_done));
      check_eq($sformatf("L%0d pass_cnt", L), 32'(pass_cnt), 32'(passes));
      if (e_src) check_eq($sformatf("L%0d src_addr", L), 32'(src_addr), 32'(d));
      if (e_we) begin
        check_eq($sformatf("L%0d dst_addr", L), 32'(dst_addr), 32'(d - L - 1));
        check_eq($sformatf("L%0d dst_din", L), 32'(dst_din), 32'(src_mem[d - L - 1]));
      end
      if (final_chk) begin
        for (int i = 0; i < DEPTH; i++)
          check_eq($sformatf("L%0d dst_mem[%0d]", L, i), 32'(dst_mem[i]), 32'(src_mem[i]));
      end
    end

    // Reset must clear outputs before any clock edge arrives.
    always @(negedge n_rst) begin
      #2;
      check_eq($sformatf("L%0d rst src_en", L), 32'(src_en), 32'd0);
      check_eq($sformatf("L%0d rst src_addr", L), 32'(src_addr), 32'd0);
      check_eq($sformatf("L%0d rst dst_we", L), 32'(dst_we), 32'd0);
      check_eq($sformatf("L%0d rst dst_addr", L), 32'(dst_addr), 32'd0);
      check_eq($sformatf("L%0d rst dst_din", L), 32'(dst_din), 32'd0);
      check_eq($sformatf("L%0d rst busy", L), 32'(busy), 32'd0);
      check_eq($sformatf("L%0d rst done", L), 32'(done), 32'd0);
      check_eq($sformatf("L%0d rst pass_cnt", L), 32'(pass_cnt), 32'd0);
    end
  end

  initial begin
    n_rst      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;
    wrap_load  = 1'b0;
    clr_dst    = 1'b0;
    final_chk  = 1'b0;
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 24'(32'hA00 + i);
    #1 n_rst = 1'b0;
    tick(3);
    n_rst = 1'b1;
    tick(2);

    // One-shot copy
    start = 1'b1; tick(1); start = 1'b0;
    tick(20);

    // Continuous for three passes, then dropped
    continuous = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(30);
    continuous = 1'b0;
    tick(25);

    // Abort while src_addr = 4, then a clean pass
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(5);
    start = 1'b1; tick(1); start = 1'b0;
    tick(20);

    // start held through a busy pass
    start = 1'b1; tick(15); start = 1'b0;
    tick(25);

    // start together with abort in IDLE
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    tick(3);

    // Async reset in the middle of DRAIN
    start = 1'b1; tick(1); start = 1'b0;
    tick(9);
    #1 n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(2);

    // pass_cnt wrap from 0xFFFF
    #1;
    force g_lat[0].u_dut.pass_cnt_q = 16'hFFFF;
    force g_lat[1].u_dut.pass_cnt_q = 16'hFFFF;
    force g_lat[2].u_dut.pass_cnt_q = 16'hFFFF;
    wrap_load = 1'b1;
    @(negedge clk);
    #1;
    release g_lat[0].u_dut.pass_cnt_q;
    release g_lat[1].u_dut.pass_cnt_q;
    release g_lat[2].u_dut.pass_cnt_q;
    wrap_load = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(20);

    // Randomized start/abort/continuous traffic over random source data
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 24'($urandom);
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(5) == 0);
      abort = ($urandom_range(49) == 0);
      if ($urandom_range(19) == 0) continuous = ~continuous;
      tick(1);
    end
    start = 1'b0; continuous = 1'b0;
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(2);

    // Fresh pattern, cleared destination, one full pass, compare memories
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 24'($urandom);
    clr_dst = 1'b1; tick(1); clr_dst = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(20);
    #1 final_chk = 1'b1;
    @(negedge clk);
    #1 final_chk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
